// File: rtl/regfile_alu_seq.sv
// Sequential register file + ALU: a start request either loads an immediate
// or runs a READ -> EXEC -> WB pass through the ALU with optional write-back.
module regfile_alu_seq #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              Load,
  input  logic [DATA_W-1:0] Imm,
  input  logic [ADDR_W-1:0] R_Addr_A,
  input  logic [ADDR_W-1:0] R_Addr_B,
  input  logic [ADDR_W-1:0] W_Addr,
  input  logic [3:0]        ALU_OP,
  input  logic              Reg_Write,
  input  logic [ADDR_W-1:0] Dbg_Addr,
  output logic [DATA_W-1:0] Dbg_Data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] F,
  output logic [3:0]        FR
);

  localparam int NREG = 2 ** ADDR_W;
  localparam int SH_W = $clog2(DATA_W);
  localparam int MSB  = DATA_W - 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EXEC = 2'd2,
    WB   = 2'd3
  } state_t;

  state_t            state_r;
  logic [DATA_W-1:0] regs_r [NREG];
  logic              load_r;
  logic              rw_r;
  logic [DATA_W-1:0] imm_r;
  logic [ADDR_W-1:0] ra_r;
  logic [ADDR_W-1:0] rb_r;
  logic [ADDR_W-1:0] wa_r;
  logic [3:0]        op_r;
  logic [DATA_W-1:0] a_r;
  logic [DATA_W-1:0] b_r;

  logic [DATA_W:0]   add_s;
  logic [DATA_W:0]   sub_s;
  logic [SH_W-1:0]   shamt_s;
  logic [DATA_W-1:0] f_s;
  logic              cf_s;
  logic              of_s;
  logic [3:0]        fr_s;

  // Register 0 reads as zero when it is the hardwired-zero register.
  function automatic logic [DATA_W-1:0] zmask(input logic [ADDR_W-1:0] addr,
                                              input logic [DATA_W-1:0] data);
    if ((ZERO_REG != 0) && (addr == {ADDR_W{1'b0}})) begin
      return {DATA_W{1'b0}};
    end else begin
      return data;
    end
  endfunction

  assign Dbg_Data = zmask(Dbg_Addr, regs_r[Dbg_Addr]);
  assign add_s    = {1'b0, a_r} + {1'b0, b_r};
  assign sub_s    = {1'b0, a_r} - {1'b0, b_r};
  assign shamt_s  = b_r[SH_W-1:0];

  // ALU result and flags from the latched operands.
  always_comb begin
    f_s  = {DATA_W{1'b0}};
    cf_s = 1'b0;
    of_s = 1'b0;
    case (op_r)
      4'b0000: begin
        f_s  = add_s[MSB:0];
        cf_s = add_s[DATA_W];
        of_s = (a_r[MSB] == b_r[MSB]) && (add_s[MSB] != a_r[MSB]);
      end
      4'b1000: begin
        f_s  = sub_s[MSB:0];
        cf_s = sub_s[DATA_W];   // borrow, i.e. A < B unsigned
        of_s = (a_r[MSB] != b_r[MSB]) && (sub_s[MSB] != a_r[MSB]);
      end
      4'b0001: f_s = a_r << shamt_s;
      4'b0101: f_s = a_r >> shamt_s;
      4'b1101: f_s = $unsigned($signed(a_r) >>> shamt_s);
      4'b0010: f_s = {{(DATA_W-1){1'b0}}, ($signed(a_r) < $signed(b_r))};
      4'b0011: f_s = {{(DATA_W-1){1'b0}}, (a_r < b_r)};
      4'b0100: f_s = a_r ^ b_r;
      4'b0110: f_s = a_r | b_r;
      4'b0111: f_s = a_r & b_r;
      default: f_s = {DATA_W{1'b0}};
    endcase
    fr_s = {f_s[MSB], of_s, cf_s, (f_s == {DATA_W{1'b0}})};
  end

  // Sequencer, operand/result registers and register-file write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      F       <= {DATA_W{1'b0}};
      FR      <= 4'b0000;
      a_r     <= {DATA_W{1'b0}};
      b_r     <= {DATA_W{1'b0}};
      load_r  <= 1'b0;
      rw_r    <= 1'b0;
      imm_r   <= {DATA_W{1'b0}};
      ra_r    <= {ADDR_W{1'b0}};
      rb_r    <= {ADDR_W{1'b0}};
      wa_r    <= {ADDR_W{1'b0}};
      op_r    <= 4'b0000;
      for (int i = 0; i < NREG; i++) begin
        regs_r[i] <= {DATA_W{1'b0}};
      end
    end else begin
      done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            load_r  <= Load;
            rw_r    <= Reg_Write;
            imm_r   <= Imm;
            ra_r    <= R_Addr_A;
            rb_r    <= R_Addr_B;
            wa_r    <= W_Addr;
            op_r    <= ALU_OP;
            busy    <= 1'b1;
            state_r <= Load ? WB : READ;
          end else begin
            busy    <= 1'b0;
            state_r <= IDLE;
          end
        end
        READ: begin
          a_r     <= zmask(ra_r, regs_r[ra_r]);
          b_r     <= zmask(rb_r, regs_r[rb_r]);
          state_r <= EXEC;
        end
        EXEC: begin
          F       <= f_s;
          FR      <= fr_s;
          state_r <= WB;
        end
        WB: begin
          if ((load_r || rw_r) &&
              !((ZERO_REG != 0) && (wa_r == {ADDR_W{1'b0}}))) begin
            regs_r[wa_r] <= load_r ? imm_r : F;
          end
          done    <= 1'b1;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_alu_seq.sv
// Directed bench for regfile_alu_seq with hand-computed expectations.
module tb_regfile_alu_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        Load;
  logic [31:0] Imm;
  logic [4:0]  R_Addr_A;
  logic [4:0]  R_Addr_B;
  logic [4:0]  W_Addr;
  logic [3:0]  ALU_OP;
  logic        Reg_Write;
  logic [4:0]  Dbg_Addr;
  logic [31:0] Dbg_Data;
  logic        busy;
  logic        done;
  logic [31:0] F;
  logic [3:0]  FR;

  int tests = 0;
  int fails = 0;

  regfile_alu_seq dut (
    .clk(clk), .rst(rst), .start(start), .Load(Load), .Imm(Imm),
    .R_Addr_A(R_Addr_A), .R_Addr_B(R_Addr_B), .W_Addr(W_Addr),
    .ALU_OP(ALU_OP), .Reg_Write(Reg_Write), .Dbg_Addr(Dbg_Addr),
    .Dbg_Data(Dbg_Data), .busy(busy), .done(done), .F(F), .FR(FR)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_reg(input string tag, input logic [4:0] a, input logic [31:0] exp);
    @(negedge clk);
    Dbg_Addr = a;
    #1;
    check_eq(tag, {32'd0, Dbg_Data}, {32'd0, exp});
  endtask

  // Issue one request, then check done latency and that done is a single pulse.
  task automatic run_op(input string tag, input logic ld, input logic [31:0] imm,
                        input logic [4:0] ra, input logic [4:0] rb, input logic [4:0] wa,
                        input logic [3:0] op, input logic rw);
    int n;
    @(negedge clk);
    start = 1'b1; Load = ld; Imm = imm; R_Addr_A = ra; R_Addr_B = rb;
    W_Addr = wa; ALU_OP = op; Reg_Write = rw;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      n++;
      if (done) break;
    end
    check_eq({tag, "_lat"}, 64'(n), ld ? 64'd1 : 64'd3);
    @(posedge clk); #1;
    check_eq({tag, "_pulse"}, {63'd0, done}, 64'd0);
  endtask

  task automatic check_res(input string tag, input logic [31:0] ef, input logic [3:0] efr);
    check_eq({tag, "_F"}, {32'd0, F}, {32'd0, ef});
    check_eq({tag, "_FR"}, {60'd0, FR}, {60'd0, efr});
  endtask

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; Load = 1'b0; Imm = 32'd0; R_Addr_A = 5'd0;
    R_Addr_B = 5'd0; W_Addr = 5'd0; ALU_OP = 4'd0; Reg_Write = 1'b0; Dbg_Addr = 5'd0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_eq("rst_F", {32'd0, F}, 64'd0);
    check_eq("rst_FR", {60'd0, FR}, 64'd0);
    check_eq("rst_busy", {63'd0, busy}, 64'd0);
    check_eq("rst_done", {63'd0, done}, 64'd0);
    for (int a = 0; a < 32; a++) check_reg("rst_reg", 5'(a), 32'd0);

    run_op("ld_r1", 1'b1, 32'h7FFF_FFFF, 5'd0, 5'd0, 5'd1, 4'd0, 1'b0);
    check_reg("r1", 5'd1, 32'h7FFF_FFFF);
    run_op("ld_r2", 1'b1, 32'h0000_0001, 5'd0, 5'd0, 5'd2, 4'd0, 1'b0);
    run_op("add", 1'b0, 32'd0, 5'd1, 5'd2, 5'd3, 4'b0000, 1'b1);
    check_res("add", 32'h8000_0000, 4'b1100);
    check_reg("r3", 5'd3, 32'h8000_0000);

    run_op("ld_r7", 1'b1, 32'd4, 5'd0, 5'd0, 5'd7, 4'd0, 1'b0);
    check_res("ld_hold", 32'h8000_0000, 4'b1100);

    run_op("sub0", 1'b0, 32'd0, 5'd2, 5'd2, 5'd4, 4'b1000, 1'b1);
    check_res("sub0", 32'h0000_0000, 4'b0001);
    run_op("subneg", 1'b0, 32'd0, 5'd0, 5'd2, 5'd5, 4'b1000, 1'b1);
    check_res("subneg", 32'hFFFF_FFFF, 4'b1010);
    check_reg("r5", 5'd5, 32'hFFFF_FFFF);

    run_op("sra", 1'b0, 32'd0, 5'd3, 5'd7, 5'd6, 4'b1101, 1'b1);
    check_res("sra", 32'hF800_0000, 4'b1000);
    check_reg("r6", 5'd6, 32'hF800_0000);
    run_op("sltu", 1'b0, 32'd0, 5'd2, 5'd1, 5'd6, 4'b0011, 1'b0);
    check_res("sltu", 32'h0000_0001, 4'b0000);
    check_reg("r6_kept", 5'd6, 32'hF800_0000);

    run_op("slt", 1'b0, 32'd0, 5'd3, 5'd1, 5'd10, 4'b0010, 1'b1);
    check_res("slt", 32'h0000_0001, 4'b0000);
    check_reg("r10", 5'd10, 32'h0000_0001);
    run_op("srl", 1'b0, 32'd0, 5'd3, 5'd7, 5'd11, 4'b0101, 1'b1);
    check_res("srl", 32'h0800_0000, 4'b0000);
    run_op("xor", 1'b0, 32'd0, 5'd1, 5'd5, 5'd13, 4'b0100, 1'b1);
    check_res("xor", 32'h8000_0000, 4'b1000);
    run_op("or", 1'b0, 32'd0, 5'd1, 5'd3, 5'd14, 4'b0110, 1'b1);
    check_res("or", 32'hFFFF_FFFF, 4'b1000);
    run_op("and", 1'b0, 32'd0, 5'd1, 5'd3, 5'd15, 4'b0111, 1'b1);
    check_res("and", 32'h0000_0000, 4'b0001);
    run_op("addc", 1'b0, 32'd0, 5'd5, 5'd2, 5'd16, 4'b0000, 1'b1);
    check_res("addc", 32'h0000_0000, 4'b0011);
    run_op("badop", 1'b0, 32'd0, 5'd1, 5'd2, 5'd17, 4'b1111, 1'b1);
    check_res("badop", 32'h0000_0000, 4'b0001);
    run_op("ld_r19", 1'b1, 32'h0000_0024, 5'd0, 5'd0, 5'd19, 4'd0, 1'b0);
    run_op("sll", 1'b0, 32'd0, 5'd2, 5'd19, 5'd20, 4'b0001, 1'b1);
    check_res("sll", 32'h0000_0010, 4'b0000);
    check_reg("r20", 5'd20, 32'h0000_0010);

    run_op("ld_r0", 1'b1, 32'h0000_1234, 5'd0, 5'd0, 5'd0, 4'd0, 1'b0);
    check_reg("r0", 5'd0, 32'h0000_0000);

    // Second start while busy must be dropped without disturbing the first op.
    @(negedge clk);
    start = 1'b1; Load = 1'b0; R_Addr_A = 5'd1; R_Addr_B = 5'd2; W_Addr = 5'd18;
    ALU_OP = 4'b0000; Reg_Write = 1'b1;
    @(posedge clk); #1;
    Load = 1'b1; Imm = 32'h0000_0055; W_Addr = 5'd9;
    check_eq("busy_hi", {63'd0, busy}, 64'd1);
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (done) n++;
    end
    check_eq("one_done", 64'(n), 64'd1);
    check_reg("r18", 5'd18, 32'h8000_0000);
    check_reg("r9", 5'd9, 32'h0000_0000);

    // Reset while the ADD is in EXEC.
    @(negedge clk);
    start = 1'b1; Load = 1'b0; R_Addr_A = 5'd1; R_Addr_B = 5'd2; W_Addr = 5'd8;
    ALU_OP = 4'b0000; Reg_Write = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_eq("mid_busy", {63'd0, busy}, 64'd0);
    check_eq("mid_done", {63'd0, done}, 64'd0);
    check_eq("mid_F", {32'd0, F}, 64'd0);
    n = 0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      if (done) n++;
    end
    check_eq("mid_nodone", 64'(n), 64'd0);
    check_reg("r8", 5'd8, 32'h0000_0000);
    check_reg("r1_clr", 5'd1, 32'h0000_0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/regfile_alu_seq.md
REGFILE_ALU_SEQ -- requirements
Module: regfile_alu_seq

Interface
REQ-001 SHALL have parameter DATA_W, default 32, datapath and register width (8..64).
REQ-002 SHALL have parameter ADDR_W, default 5, register address width; the register count is 2**ADDR_W.
REQ-003 SHALL have parameter ZERO_REG, default 1; 1 means register 0 reads 0 and ignores writes.
REQ-004 SHALL use one clock and a synchronous, active-high reset: clk (in, 1) rising-edge clock; rst (in, 1) synchronous active-high reset.
REQ-005 SHALL have port start  in  1  request; sampled only in IDLE.
REQ-006 SHALL have port Load  in  1  at start: 1 writes Imm to W_Addr; 0 executes an ALU op.
REQ-007 SHALL have port Imm  in  DATA_W  load data.
REQ-008 SHALL have ports R_Addr_A, R_Addr_B, W_Addr  in  ADDR_W  source and destination registers.
REQ-009 SHALL have port ALU_OP  in  4  operation select.
REQ-010 SHALL have port Reg_Write  in  1  write-back enable for ALU ops.
REQ-011 SHALL have port Dbg_Addr  in  ADDR_W  debug read address.
REQ-012 SHALL have port Dbg_Data  out  DATA_W  combinational read of the register at Dbg_Addr (0 for register 0 when ZERO_REG=1).
REQ-013 SHALL have port busy  out  1  high whenever the state is not IDLE.
REQ-014 SHALL have port done  out  1  one-cycle completion pulse.
REQ-015 SHALL have port F  out  DATA_W  registered ALU result.
REQ-016 SHALL have port FR  out  4  registered flags {SF,OF,CF,ZF}, with ZF at bit 0.

Function
REQ-017 SHALL implement FSM states IDLE, READ, EXEC, WB; start=1 in IDLE latches Load, Imm, addresses, ALU_OP and Reg_Write.
REQ-018 SHALL transition IDLE->WB on start with Load=1, and IDLE->READ on start with Load=0.
REQ-019 SHALL transition READ->EXEC, EXEC->WB and WB->IDLE unconditionally.
REQ-020 SHALL latch operands A and B from the register file in READ.
REQ-021 SHALL register F and FR at the end of EXEC; F and FR then hold until the next EXEC, and a Load leaves them unchanged.
REQ-022 SHALL, at the WB->IDLE edge, write Imm (Load) or F (Reg_Write=1) to W_Addr, and set done for exactly one cycle.
REQ-023 SHALL produce done 3 edges after the start edge for an ALU op, and 1 edge after it for a Load.
REQ-024 SHALL ignore start while busy=1, with no queuing.
REQ-025 SHALL define ALU_OP encodings: 0000 ADD, 1000 SUB, 0001 SLL, 0101 SRL, 1101 SRA, 0010 SLT, 0011 SLTU, 0100 XOR, 0110 OR, 0111 AND; every other encoding gives F=0.
REQ-026 SHALL take shift amounts from the low $clog2(DATA_W) bits of B.
REQ-027 SHALL make SLT/SLTU produce 1 or 0 zero-extended to DATA_W.
REQ-028 SHALL compute ZF=(F==0) and SF=F[DATA_W-1] for every op.
REQ-029 SHALL set CF to the carry-out for ADD and to the borrow (A<B unsigned) for SUB, and 0 for all other ops.
REQ-030 SHALL set OF to signed overflow for ADD/SUB, and 0 for all other ops.
REQ-031 SHALL, when ZERO_REG=1, suppress any write to register 0 while still pulsing done.
REQ-032 SHALL make a register written at WB visible on Dbg_Data in the next cycle and to the next READ.

Reset
REQ-033 SHALL, when rst=1 at a clock edge, force state IDLE; busy, done, F, FR, A and B to 0; and every register to 0.
REQ-034 SHALL give rst priority over start and over any in-flight operation; a reset during READ, EXEC or WB performs no write and produces no done.

Verification
REQ-035 SHALL verify reset: rst for 2 cycles -> Dbg_Data=0 for all 32 addresses, F=0, FR=0, busy=0, done=0.
REQ-036 SHALL verify loads and ADD: Load r1=0x7FFFFFFF, Load r2=1, ADD r3=r1+r2 with Reg_Write=1 -> done 3 edges after start, F=0x80000000, FR=4'b1100, Dbg r3=0x80000000.
REQ-037 SHALL verify SUB: SUB r4=r2-r2 -> F=0, FR=4'b0001; then SUB r5=r0-r2 -> F=0xFFFFFFFF, FR=4'b1010.
REQ-038 SHALL verify SRA: SRA r6=r3 by r7, where Load r7=4 -> F=0xF8000000, FR=4'b1000; SLTU with Reg_Write=0 -> destination register unchanged.
REQ-039 SHALL verify register 0 protection: Load r0=0x1234 -> done pulses, Dbg r0=0; a start pulsed during busy -> ignored, with exactly one done per accepted start.
REQ-040 SHALL verify reset mid-operation: rst asserted in EXEC of ADD r8 -> busy=0 next cycle, no done, Dbg r8=0.
